// File: rtl/fir_axil_mac_if.sv
// AXI4-Lite slave-port bundle for fir_axil_mac; names follow the AXI channel signals.
interface fir_axil_mac_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] AWADDR;
   logic [2:0]        AWPROT;
   logic              AWVALID;
   logic              AWREADY;
   logic [31:0]       WDATA;
   logic [3:0]        WSTRB;
   logic              WVALID;
   logic              WREADY;
   logic [1:0]        BRESP;
   logic              BVALID;
   logic              BREADY;
   logic [ADDR_W-1:0] ARADDR;
   logic [2:0]        ARPROT;
   logic              ARVALID;
   logic              ARREADY;
   logic [31:0]       RDATA;
   logic [1:0]        RRESP;
   logic              RVALID;
   logic              RREADY;

   modport slave (
      input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
      input  ARADDR, ARPROT, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport master (
      output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
      output ARADDR, ARPROT, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/fir_axil_mac.sv
// AXI4-Lite FIR engine with sequential MAC; result ready NUM_TAPS+1 cycles after a sample write.
// One transaction per channel in flight (ready pulses only while no response is pending); FIR_SATURATE_EN selects saturating result.
module fir_axil_mac #(
   parameter int DATA_W   = 16,
   parameter int NUM_TAPS = 8,
   parameter int ADDR_W   = 8
) (
   input  logic           ACLK,
   input  logic           ARESET,
   fir_axil_mac_if.slave  s_axi,
   output logic           done_irq
);
   localparam int IDX_W = $clog2(NUM_TAPS);
   localparam int ACC_W = 2*DATA_W + IDX_W;
   localparam int EXT_W = (ACC_W > 32) ? ACC_W : 33;

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_STORE} state_t;

   state_t                    r_state, w_state_nxt;
   logic [IDX_W-1:0]          r_idx;
   logic signed [ACC_W-1:0]   r_acc;
   logic signed [DATA_W-1:0]  r_coef [NUM_TAPS];
   logic signed [DATA_W-1:0]  r_x    [NUM_TAPS];
   logic [31:0]               r_result;
   logic                      r_done, r_ovr;
   logic                      r_aw_rdy, r_bvalid, r_ar_rdy, r_rvalid;
   logic [1:0]                r_bresp;
   logic [31:0]               r_rdata;

   logic                      w_busy, w_wr_hs, w_wr_any, w_wr_is_coef, w_rd_is_coef;
   logic [ADDR_W-1:0]         w_wr_off, w_rd_off, w_wr_rel, w_rd_rel;
   logic [IDX_W-1:0]          w_wr_cidx, w_rd_cidx;
   logic                      w_sample_go, w_sample_ovr, w_clr_hist, w_clr_flags;
   logic                      w_coef_we, w_coef_err;
   logic [31:0]               w_merge, w_rd_dat, w_res;
   logic signed [2*DATA_W-1:0] w_prod;
   logic signed [EXT_W-1:0]   w_acc_ext;
   logic                      w_unused;

   assign w_busy   = (r_state != S_IDLE);
   assign w_wr_hs  = r_aw_rdy & s_axi.AWVALID & s_axi.WVALID;
   assign w_wr_any = |s_axi.WSTRB;
   assign w_wr_off = {s_axi.AWADDR[ADDR_W-1:2], 2'b00};
   assign w_rd_off = {s_axi.ARADDR[ADDR_W-1:2], 2'b00};
   assign w_wr_rel = w_wr_off - ADDR_W'(16);
   assign w_rd_rel = w_rd_off - ADDR_W'(16);
   assign w_wr_cidx = w_wr_rel[IDX_W+1:2];
   assign w_rd_cidx = w_rd_rel[IDX_W+1:2];
   assign w_wr_is_coef = (w_wr_off >= ADDR_W'(16)) && (w_wr_off < ADDR_W'(16 + 4*NUM_TAPS));
   assign w_rd_is_coef = (w_rd_off >= ADDR_W'(16)) && (w_rd_off < ADDR_W'(16 + 4*NUM_TAPS));

   assign w_sample_go  = w_wr_hs && w_wr_any && (w_wr_off == ADDR_W'(8)) && !w_busy;
   assign w_sample_ovr = w_wr_hs && w_wr_any && (w_wr_off == ADDR_W'(8)) && w_busy;
   assign w_clr_hist   = w_wr_hs && w_wr_any && (w_wr_off == ADDR_W'(0)) && s_axi.WDATA[0] && !w_busy;
   assign w_clr_flags  = w_wr_hs && w_wr_any && (w_wr_off == ADDR_W'(0)) && s_axi.WDATA[1];
   assign w_coef_we    = w_wr_hs && w_wr_is_coef && !w_busy;
   assign w_coef_err   = w_wr_hs && w_wr_is_coef && w_busy;

   assign w_prod    = r_coef[r_idx] * r_x[r_idx];
   assign w_acc_ext = EXT_W'(r_acc);

   assign s_axi.AWREADY = r_aw_rdy;
   assign s_axi.WREADY  = r_aw_rdy;
   assign s_axi.BVALID  = r_bvalid;
   assign s_axi.BRESP   = r_bresp;
   assign s_axi.ARREADY = r_ar_rdy;
   assign s_axi.RVALID  = r_rvalid;
   assign s_axi.RDATA   = r_rdata;
   assign s_axi.RRESP   = 2'b00;
   assign done_irq      = r_done;

   assign w_unused = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.AWADDR[1:0], s_axi.ARADDR[1:0],
                       w_merge, w_acc_ext, w_wr_rel, w_rd_rel};

   // Byte-lane merge over the zero-extended stored coefficient; bits above DATA_W fall away.
   always_comb begin
      w_merge = {{(32-DATA_W){1'b0}}, r_coef[w_wr_cidx]};
      for (int b = 0; b < 4; b++) begin
         if (s_axi.WSTRB[b]) w_merge[8*b +: 8] = s_axi.WDATA[8*b +: 8];
      end
   end

   always_comb begin
      w_rd_dat = 32'h0;
      if (w_rd_off == ADDR_W'(4))
         w_rd_dat = {29'h0, r_ovr, r_done, w_busy};
      else if (w_rd_off == ADDR_W'(12))
         w_rd_dat = r_result;
      else if (w_rd_is_coef)
         w_rd_dat = {{(32-DATA_W){r_coef[w_rd_cidx][DATA_W-1]}}, r_coef[w_rd_cidx]};
   end

   always_comb begin
      w_res = w_acc_ext[31:0];
`ifdef FIR_SATURATE_EN
      if (w_acc_ext[EXT_W-1:31] != {(EXT_W-31){w_acc_ext[EXT_W-1]}})
         w_res = w_acc_ext[EXT_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_sample_go) w_state_nxt = S_MAC;
         S_MAC:   if (r_idx == IDX_W'(NUM_TAPS-1)) w_state_nxt = S_STORE;
         S_STORE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
         r_ovr    <= 1'b0;
         r_aw_rdy <= 1'b0;
         r_bvalid <= 1'b0;
         r_bresp  <= 2'b00;
         r_ar_rdy <= 1'b0;
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         for (int k = 0; k < NUM_TAPS; k++) begin
            r_coef[k] <= '0;
            r_x[k]    <= '0;
         end
      end else begin
         r_state  <= w_state_nxt;
         r_aw_rdy <= s_axi.AWVALID && s_axi.WVALID && !r_bvalid && !r_aw_rdy;
         if (w_wr_hs) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_coef_err ? 2'b10 : 2'b00;
         end else if (r_bvalid && s_axi.BREADY) begin
            r_bvalid <= 1'b0;
            r_bresp  <= 2'b00;
         end

         r_ar_rdy <= s_axi.ARVALID && !r_rvalid && !r_ar_rdy;
         if (r_ar_rdy && s_axi.ARVALID) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_dat;
         end else if (r_rvalid && s_axi.RREADY) begin
            r_rvalid <= 1'b0;
         end

         if (w_coef_we) r_coef[w_wr_cidx] <= w_merge[DATA_W-1:0];

         if (w_sample_go) begin
            r_x[0] <= s_axi.WDATA[DATA_W-1:0];
            for (int k = 1; k < NUM_TAPS; k++) r_x[k] <= r_x[k-1];
         end else if (w_clr_hist) begin
            for (int k = 0; k < NUM_TAPS; k++) r_x[k] <= '0;
         end

         // STORE is last so a coincident CLR_FLAGS leaves DONE set.
         if (w_clr_flags) begin
            r_done <= 1'b0;
            r_ovr  <= 1'b0;
         end
         if (w_sample_ovr) r_ovr <= 1'b1;
         if (w_sample_go) r_done <= 1'b0;
         if (r_state == S_STORE) begin
            r_done   <= 1'b1;
            r_result <= w_res;
         end

         if (r_state == S_IDLE) begin
            r_idx <= '0;
            r_acc <= '0;
         end else if (r_state == S_MAC) begin
            r_acc <= r_acc + ACC_W'(w_prod);
            r_idx <= r_idx + 1'b1;
         end
      end
   end
endmodule
